// File: rtl/dmem_resp_pkg.sv
// Shared constants and types for the data-memory responder.
package dmem_resp_pkg;

  localparam logic [2:0] SIZE_B = 3'b001;
  localparam logic [2:0] SIZE_H = 3'b010;
  localparam logic [2:0] SIZE_W = 3'b100;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MISAL = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_INIT  = 2'b11;

  typedef enum logic {StInit, StReady} dmem_state_t;

  function automatic logic size_is_onehot(input logic [2:0] size);
    return size inside {SIZE_B, SIZE_H, SIZE_W};
  endfunction

endpackage

// File: rtl/dmem_resp_lane_align.sv
// Byte-lane steering: store byte-enables, store-data replication, load shift and mask.
module dmem_lane_align
  import dmem_resp_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      size_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_data_o
);

  logic [XLEN-1:0] w_mask;
  logic [XLEN-1:0] w_shifted;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = store_data_i;
    w_mask  = '0;
    case (size_i)
      SIZE_B: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{store_data_i[7:0]}};
        w_mask  = 32'h0000_00ff;
      end
      SIZE_H: begin
        be_o    = 4'b0011 << off_i;
        wdata_o = {2{store_data_i[15:0]}};
        w_mask  = 32'h0000_ffff;
      end
      SIZE_W: begin
        be_o    = 4'b1111;
        w_mask  = 32'hffff_ffff;
      end
      default: ;
    endcase
  end

  assign w_shifted   = rdata_i >> {off_i, 3'b000};
  assign load_data_o = w_shifted & w_mask;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: word array with byte-lane writes, post-reset clear and sticky errors.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADR    = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            adr_v_i,
  input  logic [XLEN-1:0] adr_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [2:0]      access_size_i,
  output logic [XLEN-1:0] load_data_o,
  output logic            init_done_o,
  output logic            err_o,
  output logic [XLEN-1:0] err_adr_o,
  output logic [1:0]      err_cause_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dmem_state_t     r_state, w_state_nxt;
  logic [AW-1:0]   r_ptr, w_ptr_nxt;
  logic            r_err;
  logic [XLEN-1:0] r_err_adr;
  logic [1:0]      r_err_cause;
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  logic [XLEN-1:0] w_rel;
  logic [AW-1:0]   w_idx;
  logic [1:0]      w_off;
  logic            w_in_range;
  logic            w_misal;
  logic [1:0]      w_cause;
  logic            w_access_ok;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_rdata;
  logic [XLEN-1:0] w_ld_aligned;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_idx;
  logic [3:0]      w_mem_be;
  logic [XLEN-1:0] w_mem_wdata;

  // BASE_ADR is aligned to the array span, so the offset's upper bits alone decide range.
  assign w_rel      = adr_i - BASE_ADR;
  assign w_idx      = w_rel[AW+1:2];
  assign w_off      = w_rel[1:0];
  assign w_in_range = (w_rel[XLEN-1:AW+2] == '0);
  assign w_misal    = ((access_size_i == SIZE_H) && w_off[0]) ||
                      ((access_size_i == SIZE_W) && (w_off != 2'b00));

  always_comb begin
    w_cause = ERR_NONE;
    if ((r_state != StReady) || !size_is_onehot(access_size_i)) begin
      w_cause = ERR_INIT;
    end else if (!w_in_range) begin
      w_cause = ERR_RANGE;
    end else if (w_misal) begin
      w_cause = ERR_MISAL;
    end
  end

  assign w_access_ok = adr_v_i && (w_cause == ERR_NONE);

  dmem_lane_align #(
    .XLEN (XLEN)
  ) u_lane_align (
    .size_i       (access_size_i),
    .off_i        (w_off),
    .store_data_i (store_data_i),
    .rdata_i      (w_rdata),
    .be_o         (w_be),
    .wdata_o      (w_wdata),
    .load_data_o  (w_ld_aligned)
  );

  assign w_rdata     = r_mem[w_idx];
  assign load_data_o = (w_access_ok && !is_store_i) ? w_ld_aligned : '0;
  assign init_done_o = (r_state == StReady);
  assign err_o       = r_err;
  assign err_adr_o   = r_err_adr;
  assign err_cause_o = r_err_cause;

  // The clear sequencer owns the write port for the whole of INIT.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_mem_we    = 1'b0;
    w_mem_idx   = w_idx;
    w_mem_be    = w_be;
    w_mem_wdata = w_wdata;
    unique case (r_state)
      StInit: begin
        w_mem_we    = 1'b1;
        w_mem_idx   = r_ptr;
        w_mem_be    = 4'b1111;
        w_mem_wdata = '0;
        w_ptr_nxt   = r_ptr + AW'(1);
        if (&r_ptr) begin
          w_state_nxt = StReady;
        end
      end
      StReady: begin
        w_mem_we = w_access_ok && is_store_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StInit;
      r_ptr       <= '0;
      r_err       <= 1'b0;
      r_err_adr   <= '0;
      r_err_cause <= ERR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if (adr_v_i && (w_cause != ERR_NONE) && !r_err) begin
        r_err       <= 1'b1;
        r_err_adr   <= adr_i;
        r_err_cause <= w_cause;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mem_be[b]) begin
          r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed vector table, INIT/reset sequences, random vs model.
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        adr_v_i = 1'b0;
  logic [31:0] adr_i = '0;
  logic        is_store_i = 1'b0;
  logic [31:0] store_data_i = '0;
  logic [2:0]  access_size_i = SIZE_W;
  logic [31:0] load_data_o;
  logic        init_done_o;
  logic        err_o;
  logic [31:0] err_adr_o;
  logic [1:0]  err_cause_o;

  always #5 clk = ~clk;

  dmem_resp #(
    .XLEN        (32),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADR    (BASE)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .adr_v_i       (adr_v_i),
    .adr_i         (adr_i),
    .is_store_i    (is_store_i),
    .store_data_i  (store_data_i),
    .access_size_i (access_size_i),
    .load_data_o   (load_data_o),
    .init_done_o   (init_done_o),
    .err_o         (err_o),
    .err_adr_o     (err_adr_o),
    .err_cause_o   (err_cause_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: byte-addressed memory, edge count since reset, sticky error record.
  byte unsigned mb [DEPTH*4];
  int           m_cyc;
  bit           m_err;
  logic [31:0]  m_eadr;
  logic [1:0]   m_ecause;

  typedef struct {
    logic        v;
    logic        st;
    logic [2:0]  sz;
    logic [31:0] adr;
    logic [31:0] data;
    logic        chk_ld;
    logic [31:0] exp_ld;
    logic        exp_err;
    logic [31:0] exp_eadr;
    logic [1:0]  exp_ec;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] sz);
    if (sz == 3'b001) return 1;
    if (sz == 3'b010) return 2;
    if (sz == 3'b100) return 4;
    return 0;
  endfunction

  function automatic logic [1:0] m_cause(input logic [31:0] adr, input logic [2:0] sz);
    int n;
    longint a;
    n = size_bytes(sz);
    a = longint'(adr);
    if (m_cyc < DEPTH || n == 0) return 2'b11;
    if (a < longint'(BASE) || a >= longint'(BASE) + DEPTH * 4) return 2'b10;
    if ((a % n) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] adr, input logic [2:0] sz);
    logic [31:0] val;
    int a;
    val = '0;
    a = int'(adr - BASE);
    for (int i = 0; i < size_bytes(sz); i++) val |= 32'(mb[a + i]) << (8 * i);
    return val;
  endfunction

  // Called one time unit after a posedge; leaves time at the following negedge for sampling.
  task automatic drive(input logic v, input logic [31:0] adr, input logic st,
                       input logic [31:0] data, input logic [2:0] sz);
    adr_v_i       = v;
    adr_i         = adr;
    is_store_i    = st;
    store_data_i  = data;
    access_size_i = sz;
    #4;
  endtask

  task automatic check_all(input string tag);
    logic [1:0]  c;
    logic [31:0] exp_ld;
    c = m_cause(adr_i, access_size_i);
    exp_ld = (adr_v_i && !is_store_i && c == 2'b00) ? m_load(adr_i, access_size_i) : '0;
    if (!(adr_v_i && is_store_i && c == 2'b00)) chk({tag, ".load"}, load_data_o, exp_ld);
    chk({tag, ".init_done"}, 32'(init_done_o), 32'(m_cyc >= DEPTH));
    chk({tag, ".err"}, 32'(err_o), 32'(m_err));
    chk({tag, ".err_adr"}, err_adr_o, m_eadr);
    chk({tag, ".err_cause"}, 32'(err_cause_o), 32'(m_ecause));
  endtask

  task automatic edge_step();
    logic [1:0] c;
    int a;
    c = m_cause(adr_i, access_size_i);
    if (adr_v_i && c != 2'b00 && !m_err) begin
      m_err    = 1'b1;
      m_eadr   = adr_i;
      m_ecause = c;
    end
    if (adr_v_i && is_store_i && c == 2'b00) begin
      a = int'(adr_i - BASE);
      for (int i = 0; i < size_bytes(access_size_i); i++) mb[a + i] = store_data_i[8*i +: 8];
    end
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    adr_v_i = 1'b0;
    reset_n = 1'b0;
    #5;
    chk("rst.init_done", 32'(init_done_o), 32'd0);
    chk("rst.err", 32'(err_o), 32'd0);
    chk("rst.err_adr", err_adr_o, 32'd0);
    chk("rst.err_cause", 32'(err_cause_o), 32'd0);
    chk("rst.load", load_data_o, 32'd0);
    #5;
    reset_n  = 1'b1;
    m_cyc    = 0;
    m_err    = 1'b0;
    m_eadr   = '0;
    m_ecause = 2'b00;
    for (int i = 0; i < DEPTH * 4; i++) mb[i] = 8'h00;
  endtask

  task automatic wait_init(input string tag);
    int cnt;
    cnt = 0;
    adr_v_i = 1'b0;
    for (int i = 0; i < DEPTH + 100; i++) begin
      if (init_done_o) break;
      @(posedge clk);
      #1;
      cnt++;
    end
    chk({tag, ".init_cycles"}, 32'(cnt), 32'(DEPTH));
    m_cyc += cnt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rv, rst;
    logic [2:0]  rsz;
    logic [31:0] radr;
    int          r, off;

    tbl[0]  = '{1, 1, SIZE_W, 32'h10, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0,  2'b00};
    tbl[1]  = '{1, 0, SIZE_B, 32'h11, 32'h0,        1, 32'h000000BE, 0, 32'h0,  2'b00};
    tbl[2]  = '{1, 0, SIZE_H, 32'h12, 32'h0,        1, 32'h0000DEAD, 0, 32'h0,  2'b00};
    tbl[3]  = '{1, 0, SIZE_W, 32'h10, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0,  2'b00};
    tbl[4]  = '{1, 1, SIZE_W, 32'h10, 32'h11223344, 0, 32'h0,        0, 32'h0,  2'b00};
    tbl[5]  = '{1, 1, SIZE_B, 32'h13, 32'h000000AA, 0, 32'h0,        0, 32'h0,  2'b00};
    tbl[6]  = '{1, 0, SIZE_W, 32'h10, 32'h0,        1, 32'hAA223344, 0, 32'h0,  2'b00};
    tbl[7]  = '{1, 0, SIZE_W, 32'h14, 32'h0,        1, 32'h00000000, 0, 32'h0,  2'b00};
    tbl[8]  = '{1, 1, SIZE_W, 32'h40, 32'h00000001, 0, 32'h0,        0, 32'h0,  2'b00};
    tbl[9]  = '{1, 0, SIZE_W, 32'h40, 32'h0,        1, 32'h00000001, 0, 32'h0,  2'b00};
    tbl[10] = '{1, 0, SIZE_H, 32'h21, 32'h0,        1, 32'h00000000, 0, 32'h0,  2'b00};
    tbl[11] = '{1, 1, SIZE_W, 32'h1000, 32'h55,     1, 32'h00000000, 1, 32'h21, 2'b01};
    tbl[12] = '{1, 0, SIZE_W, 32'h0,  32'h0,        1, 32'h00000000, 1, 32'h21, 2'b01};
    tbl[13] = '{0, 0, SIZE_W, 32'h10, 32'h0,        1, 32'h00000000, 1, 32'h21, 2'b01};

    #6;
    do_reset();
    wait_init("boot");

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, BASE + 32'(i * 512 + i * 4), 1'b0, 32'h0, SIZE_W);
      check_all("zero");
      edge_step();
    end

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].adr, tbl[i].st, tbl[i].data, tbl[i].sz);
      if (tbl[i].chk_ld) chk($sformatf("vec%0d.load", i), load_data_o, tbl[i].exp_ld);
      chk($sformatf("vec%0d.err", i), 32'(err_o), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d.err_adr", i), err_adr_o, tbl[i].exp_eadr);
      chk($sformatf("vec%0d.err_cause", i), 32'(err_cause_o), 32'(tbl[i].exp_ec));
      edge_step();
    end

    // Access during INIT, then a reset mid-INIT restarts the full clear.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, SIZE_W);
      edge_step();
    end
    drive(1'b1, 32'h8, 1'b1, 32'hFFFF_FFFF, SIZE_W);
    check_all("init_acc");
    edge_step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, SIZE_W);
    chk("init_acc.err", 32'(err_o), 32'd1);
    chk("init_acc.cause", 32'(err_cause_o), 32'd3);
    chk("init_acc.adr", err_adr_o, 32'h8);
    while (m_cyc < 500) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, SIZE_W);
      edge_step();
    end
    do_reset();
    wait_init("midinit");
    chk("midinit.err", 32'(err_o), 32'd0);

    for (int n = 0; n < 400; n++) begin
      r   = int'($urandom_range(0, 15));
      rsz = (($urandom_range(0, 2)) == 0) ? SIZE_B : ((($urandom_range(0, 1)) == 0) ? SIZE_H : SIZE_W);
      if (r == 1) rsz = (($urandom_range(0, 1)) == 0) ? 3'b011 : 3'b000;
      if (r == 2) off = int'($urandom_range(0, 3));
      else if (rsz == SIZE_B) off = int'($urandom_range(0, 3));
      else if (rsz == SIZE_H) off = 2 * int'($urandom_range(0, 1));
      else off = 0;
      radr = BASE + 32'($urandom_range(0, 31) * 4 + off);
      if (r == 0) radr = radr + 32'h1000;
      rv  = ($urandom_range(0, 3) != 0);
      rst = $urandom_range(0, 1) != 0;
      drive(rv, radr, rst, $urandom, rsz);
      check_all("rand");
      edge_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
